// File: rtl/perm_reorder_fifo.sv
// Column-permutation FIFO: pairs each stored permutation with the next symbol vector and restores antenna order.
// Latency 1 cycle x_valid_i -> x_valid_o; no backpressure: full drops pushes (ovf_o), empty pops apply identity (udf_o).
module perm_reorder_fifo #(
    parameter int NCOL  = 8,
    parameter int IDXW  = 3,
    parameter int SYMW  = 2,
    parameter int DEPTH = 32,
    parameter int PTRW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 bypass_i,
    input  logic [NCOL*IDXW-1:0] perm_i,
    input  logic                 perm_valid_i,
    input  logic [NCOL*SYMW-1:0] x_i,
    input  logic                 x_valid_i,
    output logic [NCOL*SYMW-1:0] x_o,
    output logic                 x_valid_o,
    output logic [PTRW:0]        level_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 ovf_o,
    output logic                 udf_o,
    output logic                 perm_err_o
);

    localparam int              PW      = NCOL * IDXW;
    localparam int              XW      = NCOL * SYMW;
    localparam logic [PTRW:0]   DEPTH_L = (PTRW+1)'(DEPTH);
    localparam logic [IDXW:0]   NCOL_L  = (IDXW+1)'(NCOL);

    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW:0]   level;
    logic [PTRW:0]   level_nxt;
    logic            full_q;
    logic            empty_q;
    logic            ovf_q;
    logic            udf_q;
    logic [XW-1:0]   x_q;
    logic            xv_q;
    logic            err_q;

    logic            pop_req;
    logic            write_through;
    logic            do_pop;
    logic            do_push;
    logic            ovf_evt;
    logic            udf_evt;

    logic [PW-1:0]   ident;
    logic [PW-1:0]   sel_perm;
    logic [PW-1:0]   applied;
    logic            legal;
    logic [XW-1:0]   x_re;

    // Push/pop qualification. An empty FIFO with a simultaneous push and pop
    // forwards perm_i straight to the reorder stage without storing it.
    always_comb begin
        pop_req       = x_valid_i & ~bypass_i;
        write_through = pop_req & empty_q & perm_valid_i;
        do_pop        = pop_req & ~empty_q;
        do_push       = perm_valid_i & ~write_through & (~full_q | do_pop);
        ovf_evt       = perm_valid_i & full_q & ~do_pop;
        udf_evt       = pop_req & empty_q & ~perm_valid_i;
    end

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_nxt = level - 1'b1;
        end
    end

    always_comb begin
        ident = '0;
        for (int k = 0; k < NCOL; k++) begin
            ident[k*IDXW +: IDXW] = IDXW'(k);
        end
    end

    always_comb begin
        sel_perm = ident;
        if (!bypass_i) begin
            if (!empty_q) begin
                sel_perm = mem[rd_ptr];
            end else if (perm_valid_i) begin
                sel_perm = perm_i;
            end
        end
    end

    // Legal means every field indexes a real column and no column is used twice.
    always_comb begin
        legal = 1'b1;
        for (int k = 0; k < NCOL; k++) begin
            if ({1'b0, sel_perm[k*IDXW +: IDXW]} >= NCOL_L) begin
                legal = 1'b0;
            end
            for (int m = k + 1; m < NCOL; m++) begin
                if (sel_perm[k*IDXW +: IDXW] == sel_perm[m*IDXW +: IDXW]) begin
                    legal = 1'b0;
                end
            end
        end
    end

    assign applied = legal ? sel_perm : ident;

    // Inverse permutation: output slot j takes the input symbol whose field names j.
    always_comb begin
        x_re = '0;
        for (int j = 0; j < NCOL; j++) begin
            for (int k = 0; k < NCOL; k++) begin
                if (applied[k*IDXW +: IDXW] == IDXW'(j)) begin
                    x_re[j*SYMW +: SYMW] = x_i[k*SYMW +: SYMW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem[wr_ptr] <= perm_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (clr_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level   <= level_nxt;
            full_q  <= (level_nxt == DEPTH_L);
            empty_q <= (level_nxt == '0);
            ovf_q   <= ovf_q | ovf_evt;
            udf_q   <= udf_q | udf_evt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            xv_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (clr_i) begin
            x_q   <= '0;
            xv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            xv_q  <= x_valid_i;
            err_q <= x_valid_i & ~legal;
            if (x_valid_i) begin
                x_q <= x_re;
            end
        end
    end

    assign x_o        = x_q;
    assign x_valid_o  = xv_q;
    assign level_o    = level;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign ovf_o      = ovf_q;
    assign udf_o      = udf_q;
    assign perm_err_o = err_q;

endmodule

// File: tb/tb_perm_reorder_fifo.sv
// Randomised and directed bench for perm_reorder_fifo with a queue-based reference model and scoreboard.
module tb_perm_reorder_fifo;

    localparam int NCOL  = 8;
    localparam int IDXW  = 3;
    localparam int SYMW  = 2;
    localparam int DEPTH = 32;
    localparam int PTRW  = 5;
    localparam int PW    = NCOL * IDXW;
    localparam int XW    = NCOL * SYMW;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_i;
    logic          bypass_i;
    logic [PW-1:0] perm_i;
    logic          perm_valid_i;
    logic [XW-1:0] x_i;
    logic          x_valid_i;
    logic [XW-1:0] x_o;
    logic          x_valid_o;
    logic [PTRW:0] level_o;
    logic          full_o;
    logic          empty_o;
    logic          ovf_o;
    logic          udf_o;
    logic          perm_err_o;

    perm_reorder_fifo #(
        .NCOL(NCOL), .IDXW(IDXW), .SYMW(SYMW), .DEPTH(DEPTH), .PTRW(PTRW)
    ) dut (
        .clk(clk), .rst(rst), .clr_i(clr_i), .bypass_i(bypass_i),
        .perm_i(perm_i), .perm_valid_i(perm_valid_i),
        .x_i(x_i), .x_valid_i(x_valid_i),
        .x_o(x_o), .x_valid_o(x_valid_o), .level_o(level_o),
        .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .udf_o(udf_o),
        .perm_err_o(perm_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic          err;
    } exp_t;

    logic [PW-1:0] mq[$];
    exp_t          expq[$];
    bit            m_ovf;
    bit            m_udf;
    logic [XW-1:0] m_xo;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    endtask

    function automatic logic [PW-1:0] perm_ident();
        logic [PW-1:0] r = '0;
        for (int k = 0; k < NCOL; k++) r[k*IDXW +: IDXW] = IDXW'(k);
        return r;
    endfunction

    function automatic logic [PW-1:0] perm_rev();
        logic [PW-1:0] r = '0;
        for (int k = 0; k < NCOL; k++) r[k*IDXW +: IDXW] = IDXW'(NCOL - 1 - k);
        return r;
    endfunction

    function automatic logic [PW-1:0] rand_perm();
        int a[NCOL];
        int j, t;
        logic [PW-1:0] r = '0;
        for (int k = 0; k < NCOL; k++) a[k] = k;
        for (int i = NCOL - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = a[i]; a[i] = a[j]; a[j] = t;
        end
        for (int k = 0; k < NCOL; k++) r[k*IDXW +: IDXW] = IDXW'(a[k]);
        if ($urandom_range(99, 0) < 15)
            r[$urandom_range(NCOL - 1, 0) * IDXW +: IDXW] = IDXW'($urandom);
        return r;
    endfunction

    function automatic bit perm_is_legal(input logic [PW-1:0] p);
        bit seen[NCOL];
        int v;
        for (int k = 0; k < NCOL; k++) seen[k] = 1'b0;
        for (int k = 0; k < NCOL; k++) begin
            v = int'(p[k*IDXW +: IDXW]);
            if (v >= NCOL) return 1'b0;
            if (seen[v]) return 1'b0;
            seen[v] = 1'b1;
        end
        return 1'b1;
    endfunction

    // Output slot perm[k] receives input symbol k.
    function automatic logic [XW-1:0] ref_reorder(input logic [PW-1:0] p, input logic [XW-1:0] x);
        logic [XW-1:0] r = '0;
        int dst;
        for (int k = 0; k < NCOL; k++) begin
            dst = int'(p[k*IDXW +: IDXW]);
            r[dst*SYMW +: SYMW] = x[k*SYMW +: SYMW];
        end
        return r;
    endfunction

    task automatic model_step(input logic pv, input logic [PW-1:0] p, input logic xv,
                              input logic [XW-1:0] x, input logic byp, input logic clr);
        int            sz;
        bit            pop_req;
        bit            err;
        logic [PW-1:0] ap;
        exp_t          e;
        sz = mq.size();
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_xo  = '0;
            return;
        end
        pop_req = xv && !byp;
        if (xv) begin
            if (byp) ap = perm_ident();
            else if (sz > 0) ap = mq[0];
            else if (pv) ap = p;
            else begin
                ap = perm_ident();
                m_udf = 1'b1;
            end
            err = !perm_is_legal(ap);
            if (err) ap = perm_ident();
            m_xo  = ref_reorder(ap, x);
            e.x   = m_xo;
            e.err = err;
            expq.push_back(e);
        end
        if (pop_req && sz > 0) void'(mq.pop_front());
        if (pv && !(pop_req && sz == 0)) begin
            if (sz < DEPTH || pop_req) mq.push_back(p);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic pv, input logic [PW-1:0] p, input logic xv,
                        input logic [XW-1:0] x, input logic byp, input logic clr);
        perm_valid_i = pv;
        perm_i       = p;
        x_valid_i    = xv;
        x_i          = x;
        bypass_i     = byp;
        clr_i        = clr;
        @(posedge clk);
        model_step(pv, p, xv, x, byp, clr);
        #1;
        perm_valid_i = 1'b0;
        x_valid_i    = 1'b0;
        bypass_i     = 1'b0;
        clr_i        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (x_valid_o) begin
            if (expq.size() == 0) begin
                chk("unexpected_x_valid", 64'(x_valid_o), 64'(0));
            end else begin
                e = expq.pop_front();
                chk("x_o", 64'(x_o), 64'(e.x));
                chk("perm_err_o", 64'(perm_err_o), 64'(e.err));
            end
        end else if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("x_valid_latency", 64'(x_valid_o), 64'(1));
        end else if (perm_err_o) begin
            chk("perm_err_without_valid", 64'(perm_err_o), 64'(0));
        end
        chk("level_o", 64'(level_o), 64'(mq.size()));
        chk("full_o", 64'(full_o), 64'(mq.size() == DEPTH));
        chk("empty_o", 64'(empty_o), 64'(mq.size() == 0));
        chk("ovf_o", 64'(ovf_o), 64'(m_ovf));
        chk("udf_o", 64'(udf_o), 64'(m_udf));
        chk("x_o_hold", 64'(x_o), 64'(m_xo));
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XW-1:0] xpat;
        logic [PW-1:0] bad;
        logic          pv, xv, byp, clr;

        rst = 1'b0; clr_i = 1'b0; bypass_i = 1'b0; perm_i = '0;
        perm_valid_i = 1'b0; x_i = '0; x_valid_i = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0; m_xo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Order restore
        xpat = '0;
        for (int k = 0; k < NCOL; k++) xpat[k*SYMW +: SYMW] = SYMW'(k % 4);
        step(1'b1, perm_ident(), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, perm_rev(), 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, xpat, 1'b0, 1'b0);
        chk("restore_identity", 64'(x_o), 64'(xpat));
        step(1'b0, '0, 1'b1, xpat, 1'b0, 1'b0);
        idle(2);

        // Latency mismatch
        for (int i = 0; i < 3; i++) step(1'b1, rand_perm(), 1'b0, '0, 1'b0, 1'b0);
        idle(27);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, XW'($urandom), 1'b0, 1'b0);
        idle(2);

        // Full / overflow
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rand_perm(), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, rand_perm(), 1'b1, XW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, XW'($urandom), 1'b0, 1'b0);
        idle(2);

        // Empty cases
        step(1'b1, perm_rev(), 1'b1, xpat, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, xpat, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // Illegal permutation and bypass
        bad = perm_ident();
        bad[0 +: IDXW]    = IDXW'(3);
        bad[IDXW +: IDXW] = IDXW'(3);
        step(1'b1, bad, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, xpat, 1'b0, 1'b0);
        idle(1);
        step(1'b1, perm_rev(), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, perm_rev(), 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, xpat, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, xpat, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, xpat, 1'b0, 1'b0);
        idle(2);

        // Asynchronous reset mid-stream with level 5 and a live output
        for (int i = 0; i < 5; i++) step(1'b1, rand_perm(), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, rand_perm(), 1'b1, {XW{1'b1}}, 1'b0, 1'b0);
        rst = 1'b0;
        mq.delete(); expq.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_xo = '0;
        #1;
        chk("arst_level", 64'(level_o), 64'(0));
        chk("arst_empty", 64'(empty_o), 64'(1));
        chk("arst_x_o", 64'(x_o), 64'(0));
        chk("arst_x_valid", 64'(x_valid_o), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            pv  = ($urandom_range(99, 0) < ((c < 1500) ? 65 : 35));
            xv  = ($urandom_range(99, 0) < ((c < 1500) ? 35 : 65));
            byp = ($urandom_range(99, 0) < 10);
            clr = ($urandom_range(999, 0) < 8);
            step(pv, rand_perm(), xv, XW'($urandom), byp, clr);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
